// File: rtl/bit_packer.sv
// bit_packer: packs variable-length {data, tag} codes LSB-first into fixed OUT_WIDTH-bit words
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   in_valid/in_ready             input record handshake
//   dataIn, inTag, inLen          merged data (LSB-aligned), merged tag, valid data bit count
//   flush                         single-cycle request to zero-pad and terminate the stream
//   out_valid/out_ready           output word handshake
//   out_data, out_bits, out_last  packed word, its valid bit count, terminal-word marker
module bit_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 2,
    parameter int LEN_WIDTH  = 8,
    parameter int OUT_WIDTH  = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [2*DATA_WIDTH-1:0]          dataIn,
    input  logic [2*TAG_WIDTH-1:0]           inTag,
    input  logic [LEN_WIDTH-1:0]             inLen,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_WIDTH-1:0]             out_data,
    output logic [$clog2(OUT_WIDTH+1)-1:0]   out_bits,
    output logic                             out_last
);
    localparam int DW2   = 2 * DATA_WIDTH;
    localparam int TW2   = 2 * TAG_WIDTH;
    localparam int BUF_W = OUT_WIDTH + TW2 + DW2;
    localparam int FW    = $clog2(BUF_W + 1);
    localparam int OBW   = $clog2(OUT_WIDTH + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t             r_state, w_state_n;
    logic [BUF_W-1:0]   r_buf, w_buf_n, w_code;
    logic [FW-1:0]      r_fill, w_fill_n, w_eff_len, w_code_len;
    logic [DW2-1:0]     w_mask;
    logic [OUT_WIDTH-1:0] r_out_data, w_out_data_n;
    logic [OBW-1:0]     r_out_bits, w_out_bits_n;
    logic               r_out_valid, w_out_valid_n, r_out_last, w_out_last_n;
    logic               w_slot_free, w_accept, w_extract, w_term;

    assign w_eff_len  = (32'(inLen) > 32'(DW2)) ? FW'(DW2) : FW'(inLen);
    assign w_mask     = ~({DW2{1'b1}} << w_eff_len);
    assign w_code     = BUF_W'({dataIn & w_mask, inTag});
    assign w_code_len = FW'(TW2) + w_eff_len;

    assign in_ready    = (r_state == RUN) && (r_fill < FW'(OUT_WIDTH));
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_extract   = (r_fill >= FW'(OUT_WIDTH)) && w_slot_free;
    // buffer bits above fill are always zero, so the low word is already zero-padded
    assign w_term      = (r_state == FLUSH) && (r_fill < FW'(OUT_WIDTH)) && w_slot_free;

    always_comb begin
        w_state_n     = r_state;
        w_buf_n       = r_buf;
        w_fill_n      = r_fill;
        w_out_data_n  = r_out_data;
        w_out_bits_n  = r_out_bits;
        w_out_last_n  = r_out_last;
        w_out_valid_n = r_out_valid && !out_ready;
        if (w_extract) begin
            w_out_data_n  = r_buf[OUT_WIDTH-1:0];
            w_out_bits_n  = OBW'(OUT_WIDTH);
            w_out_last_n  = 1'b0;
            w_out_valid_n = 1'b1;
            w_buf_n       = r_buf >> OUT_WIDTH;
            w_fill_n      = r_fill - FW'(OUT_WIDTH);
        end else if (w_term) begin
            w_out_data_n  = r_buf[OUT_WIDTH-1:0];
            w_out_bits_n  = OBW'(r_fill);
            w_out_last_n  = 1'b1;
            w_out_valid_n = 1'b1;
            w_buf_n       = '0;
            w_fill_n      = '0;
            w_state_n     = RUN;
        end
        // accept only happens with fill < OUT_WIDTH, so it never overlaps an extraction
        if (w_accept) begin
            w_buf_n  = r_buf | (w_code << r_fill);
            w_fill_n = r_fill + w_code_len;
        end
        if (r_state == RUN && flush)
            w_state_n = FLUSH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_buf       <= '0;
            r_fill      <= '0;
            r_out_data  <= '0;
            r_out_bits  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_buf       <= w_buf_n;
            r_fill      <= w_fill_n;
            r_out_data  <= w_out_data_n;
            r_out_bits  <= w_out_bits_n;
            r_out_last  <= w_out_last_n;
            r_out_valid <= w_out_valid_n;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_bits  = r_out_bits;
    assign out_last  = r_out_last;
endmodule

// File: tb/tb_bit_packer.sv
// tb_bit_packer: directed stimulus with a bit-queue scoreboard for bit_packer
module tb_bit_packer;
    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [63:0] dataIn = '0;
    logic [3:0]  inTag = '0;
    logic [7:0]  inLen = '0;
    logic        in_ready, out_valid, out_last;
    logic [63:0] out_data, saved;
    logic [6:0]  out_bits;

    typedef struct {logic [63:0] d; logic [6:0] b; logic l;} exp_t;
    exp_t exp_q[$];
    exp_t mx;
    bit   mq[$];
    int   errors = 0, checks = 0;

    bit_packer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .dataIn(dataIn), .inTag(inTag), .inLen(inLen), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bits(out_bits), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_push(input logic [63:0] d, input logic [3:0] t, input logic [7:0] l);
        int e = (l > 8'd64) ? 64 : int'(l);
        for (int i = 0; i < 4; i++) mq.push_back(t[i]);
        for (int i = 0; i < e; i++) mq.push_back(d[i]);
        while (mq.size() >= 64) begin
            exp_t x;
            x.d = '0;
            for (int i = 0; i < 64; i++) x.d[i] = mq.pop_front();
            x.b = 7'd64;
            x.l = 1'b0;
            exp_q.push_back(x);
        end
    endfunction

    function automatic void model_term();
        exp_t x;
        int n = mq.size();
        x.d = '0;
        for (int i = 0; i < n; i++) x.d[i] = mq.pop_front();
        x.b = 7'(n);
        x.l = 1'b1;
        exp_q.push_back(x);
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 64'(out_valid), 64'd0);
            end else begin
                mx = exp_q.pop_front();
                check("word_data", out_data, mx.d);
                check("word_bits", 64'(out_bits), 64'(mx.b));
                check("word_last", 64'(out_last), 64'(mx.l));
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic [3:0] t, input logic [7:0] l);
        in_valid = 1'b1; dataIn = d; inTag = t; inLen = l;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                model_push(d, t, l);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_flush(input logic rec, input logic [63:0] d, input logic [3:0] t, input logic [7:0] l);
        flush = 1'b1; in_valid = rec; dataIn = d; inTag = t; inLen = l;
        @(negedge clk);
        if (rec && in_ready) model_push(d, t, l);
        model_term();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("ready_in_flush", 64'(in_ready), 64'd0);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300; c++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk); #1;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_bits", 64'(out_bits), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);

        for (int i = 0; i < 4; i++) send(64'hABC, 4'h3, 8'd12);
        check("lat_valid_low", 64'(out_valid), 64'd0);
        check("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("lat_valid_high", 64'(out_valid), 64'd1);
        send(64'hABC, 4'h3, 8'd12);
        wait_idle();

        send_flush(1'b0, '0, '0, '0);
        wait_idle();
        check("ready_after_flush", 64'(in_ready), 64'd1);
        send_flush(1'b0, '0, '0, '0);
        wait_idle();

        send('1, 4'h0, 8'd64);
        send(64'hFFFFFFFF, 4'h1, 8'd4);
        send(64'h0123_4567_89AB_CDEF, 4'h2, 8'd200);
        send(64'hFFFF_0000_5A5A, 4'h7, 8'd20);
        send_flush(1'b0, '0, '0, '0);
        wait_idle();

        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(64'(i * 273 + 5), 4'(i), 8'd12);
        repeat (3) @(posedge clk);
        #1;
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        saved = out_data;
        repeat (5) @(posedge clk);
        #1;
        check("bp_stable", out_data, saved);
        out_ready = 1'b1;
        wait_idle();

        send(64'h3_1234_5678, 4'h9, 8'd36);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", out_data, 64'd0);
        check("mid_rst_bits", 64'(out_bits), 64'd0);
        check("mid_rst_last", 64'(out_last), 64'd0);
        mq.delete();
        exp_q.delete();
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        send_flush(1'b0, '0, '0, '0);
        wait_idle();

        for (int i = 0; i < 3; i++) send(64'hABC, 4'h3, 8'd12);
        send_flush(1'b1, 64'hABC, 4'h3, 8'd12);
        wait_idle();
        check("ready_end", 64'(in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
